// File: rtl/regfile_dump.sv
// regfile_dump: walks the register file through one read port and streams
// each captured register as an (address, data, last) beat on valid/ready.
// Data is captured into the holding register at the fetch edge, so later
// register-file writes do not disturb a beat that is already presented.

module regfile_dump #(
   parameter bit SKIP_X0  = 1'b1,
   parameter int LAST_REG = 31
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [4:0]  rd_addr,
   input  logic [31:0] rd_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [4:0]  out_addr,
   output logic [31:0] out_data,
   output logic        out_last
);

   localparam logic [4:0] FIRST_IDX = (SKIP_X0 != 1'b0) ? 5'd1 : 5'd0;
   localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      FETCH   = 2'd1,
      SEND    = 2'd2,
      DONE_ST = 2'd3
   } state_t;

   state_t     state;
   logic [4:0] index;

   // The read port address is the index register itself, so it is glitch-free.
   assign rd_addr = index;

   // Dump sequencer: state, index and all registered beat/status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         index     <= FIRST_IDX;
         busy      <= 1'b0;
         done      <= 1'b0;
         out_valid <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= 32'd0;
         out_addr  <= 5'd0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (start) begin
                  state <= FETCH;
                  index <= FIRST_IDX;
                  busy  <= 1'b1;
               end else begin
                  state <= IDLE;
               end
            end
            FETCH: begin
               out_data  <= rd_data;
               out_addr  <= index;
               out_last  <= (index == LAST_IDX);
               out_valid <= 1'b1;
               state     <= SEND;
            end
            SEND: begin
               // Beat fields are left untouched until the consumer accepts.
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (out_last) begin
                     state <= DONE_ST;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     index <= index + 5'd1;
                     state <= FETCH;
                  end
               end else begin
                  state <= SEND;
               end
            end
            DONE_ST: begin
               done  <= 1'b0;
               index <= FIRST_IDX;
               state <= IDLE;
            end
            default: begin
               state     <= IDLE;
               index     <= FIRST_IDX;
               busy      <= 1'b0;
               done      <= 1'b0;
               out_valid <= 1'b0;
            end
         endcase
      end
   end

   regfile_dump_chk #(
      .SKIP_X0  (SKIP_X0),
      .LAST_REG (LAST_REG)
   ) u_chk (
      .clk     (clk),
      .busy    (busy),
      .rd_addr (rd_addr)
   );

endmodule

// regfile_dump_chk: simulation-only sanity checks on the dump range.
module regfile_dump_chk #(
   parameter bit SKIP_X0  = 1'b1,
   parameter int LAST_REG = 31
) (
   input logic       clk,
   input logic       busy,
   input logic [4:0] rd_addr
);

   localparam int FIRST_INT = (SKIP_X0 != 1'b0) ? 1 : 0;

   // The range must be non-empty and the index must stay inside it while dumping.
   always @(posedge clk) begin
      assert (LAST_REG >= FIRST_INT && LAST_REG <= 31);
      if (busy) begin
         assert (int'(rd_addr) <= LAST_REG);
      end
   end

endmodule

// File: tb/tb_regfile_dump.sv
// Bench for regfile_dump: a beat-level reference model of the default
// instance is compared every cycle, plus literal checks of the directed
// scenarios and a small second instance (x0 included, 4 registers).

module tb_regfile_dump;

   logic        clk;
   logic        rst1, start1, ready1;
   logic        busy1, done1, valid1, last1;
   logic [4:0]  rd_addr1, out_addr1;
   logic [31:0] rd_data1, out_data1;
   logic [31:0] regs1 [32];

   logic        rst2, start2, ready2;
   logic        busy2, done2, valid2, last2;
   logic [4:0]  rd_addr2, out_addr2;
   logic [31:0] rd_data2, out_data2;
   logic [31:0] regs2 [32];

   int checks = 0;
   int errors = 0;

   assign rd_data1 = regs1[rd_addr1];
   assign rd_data2 = regs2[rd_addr2];

   regfile_dump #(.SKIP_X0(1'b1), .LAST_REG(31)) dut1 (
      .clk(clk), .rst(rst1), .start(start1), .busy(busy1), .done(done1),
      .rd_addr(rd_addr1), .rd_data(rd_data1), .out_valid(valid1),
      .out_ready(ready1), .out_addr(out_addr1), .out_data(out_data1),
      .out_last(last1)
   );

   regfile_dump #(.SKIP_X0(1'b0), .LAST_REG(3)) dut2 (
      .clk(clk), .rst(rst2), .start(start2), .busy(busy2), .done(done2),
      .rd_addr(rd_addr2), .rd_data(rd_data2), .out_valid(valid2),
      .out_ready(ready2), .out_addr(out_addr2), .out_data(out_data2),
      .out_last(last2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model of dut1 (beat level) ----------------
   bit          model_on = 1'b0;
   bit          m_busy, m_done, m_valid, m_last, m_fetch;
   logic [4:0]  m_addr, m_next;
   logic [31:0] m_data;

   always @(posedge clk) begin
      if (rst1) begin
         m_busy = 1'b0; m_done = 1'b0; m_valid = 1'b0; m_last = 1'b0;
         m_fetch = 1'b0; m_data = 32'd0; m_addr = 5'd0; m_next = 5'd1;
         model_on = 1'b1;
      end else if (m_done) begin
         m_done = 1'b0;
         m_next = 5'd1;
      end else if (!m_busy) begin
         if (start1) begin
            m_busy = 1'b1; m_fetch = 1'b1; m_next = 5'd1;
         end
      end else if (m_fetch) begin
         m_data  = regs1[m_next];
         m_addr  = m_next;
         m_last  = (m_next == 5'd31);
         m_valid = 1'b1;
         m_fetch = 1'b0;
      end else if (m_valid && ready1) begin
         m_valid = 1'b0;
         if (m_last) begin
            m_busy = 1'b0; m_done = 1'b1;
         end else begin
            m_next = m_next + 5'd1; m_fetch = 1'b1;
         end
      end
   end

   // Compare every cycle, away from the rising edge.
   always @(negedge clk) begin
      if (model_on) begin
         chk("busy", {31'd0, busy1}, {31'd0, m_busy});
         chk("done", {31'd0, done1}, {31'd0, m_done});
         chk("out_valid", {31'd0, valid1}, {31'd0, m_valid});
         chk("out_addr", {27'd0, out_addr1}, {27'd0, m_addr});
         chk("out_data", out_data1, m_data);
         chk("out_last", {31'd0, last1}, {31'd0, m_last});
         chk("rd_addr", {27'd0, rd_addr1}, {27'd0, m_next});
      end
   end

   // ---------------- handshake monitors ----------------
   logic [4:0]  q1_addr [$];
   logic [31:0] q1_data [$];
   logic        q1_last [$];
   logic [4:0]  q2_addr [$];
   logic [31:0] q2_data [$];
   logic        q2_last [$];

   always @(posedge clk) begin
      if (!rst1 && valid1 && ready1) begin
         q1_addr.push_back(out_addr1); q1_data.push_back(out_data1); q1_last.push_back(last1);
      end
      if (!rst2 && valid2 && ready2) begin
         q2_addr.push_back(out_addr2); q2_data.push_back(out_data2); q2_last.push_back(last2);
      end
   end

   task automatic clear_q1();
      q1_addr.delete(); q1_data.delete(); q1_last.delete();
   endtask

   // Pulse start1 and return the cycle number (1-based after the sampling edge) of done.
   task automatic start_and_wait1(output int n);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      n = 1;
      while (!done1 && n < 400) begin
         @(negedge clk);
         n++;
      end
   endtask

   // ---------------- directed + random stimulus ----------------
   initial begin
      int n, got_done, post, dn;
      int stall7, stall10;
      bit did5;
      logic [31:0] exp_d;

      for (int i = 0; i < 32; i++) begin
         regs1[i] = 32'h1000_0000 + 32'(i);
         regs2[i] = 32'h1000_0000 + 32'(i);
      end
      regs1[0] = 32'd0;
      regs2[0] = 32'd0;
      rst1 = 1'b1; start1 = 1'b0; ready1 = 1'b1;
      rst2 = 1'b1; start2 = 1'b0; ready2 = 1'b1;
      repeat (2) @(negedge clk);
      rst1 = 1'b0; rst2 = 1'b0;

      // Reset state, literal.
      chk("rst_busy", {31'd0, busy1}, 32'd0);
      chk("rst_valid", {31'd0, valid1}, 32'd0);
      chk("rst_data", out_data1, 32'd0);
      chk("rst_addr", {27'd0, out_addr1}, 32'd0);
      chk("rst_rd_addr", {27'd0, rd_addr1}, 32'd1);
      chk("rst_rd_addr2", {27'd0, rd_addr2}, 32'd0);

      // Full dump, no backpressure.
      clear_q1();
      start_and_wait1(n);
      chk("t1_done_cycle", 32'(n), 32'd63);
      chk("t1_beats", 32'(q1_addr.size()), 32'd31);
      for (int k = 0; k < q1_addr.size(); k++) begin
         chk("t1_addr", {27'd0, q1_addr[k]}, 32'(k + 1));
         chk("t1_data", q1_data[k], 32'h1000_0000 + 32'(k + 1));
         chk("t1_last", {31'd0, q1_last[k]}, (k == 30) ? 32'd1 : 32'd0);
      end
      repeat (2) @(negedge clk);

      // Backpressure on 7, snapshot on 10/12, spurious start during beat 5.
      clear_q1();
      stall7 = 0; stall10 = 0; did5 = 1'b0; got_done = 0; post = 0; n = 0;
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      while (n < 400 && post < 4) begin
         ready1 = 1'b1;
         start1 = 1'b0;
         if (done1) got_done++;
         if (got_done > 0) post++;
         if (valid1 && out_addr1 == 5'd5 && !did5) begin
            start1 = 1'b1; did5 = 1'b1;
         end
         if (valid1 && out_addr1 == 5'd7 && stall7 < 5) begin
            chk("bp_addr", {27'd0, out_addr1}, 32'd7);
            chk("bp_data", out_data1, 32'h1000_0007);
            ready1 = 1'b0;
            stall7++;
         end
         if (valid1 && out_addr1 == 5'd10 && stall10 < 3) begin
            if (stall10 == 0) begin
               regs1[10] = 32'hDEAD_BEEF;
               regs1[12] = 32'hCAFE_F00D;
            end
            chk("snap_data", out_data1, 32'h1000_000A);
            ready1 = 1'b0;
            stall10++;
         end
         @(negedge clk);
         n++;
      end
      ready1 = 1'b1; start1 = 1'b0;
      chk("t2_stalls", 32'(stall7 + stall10), 32'd8);
      chk("t2_done_count", 32'(got_done), 32'd1);
      chk("t2_beats", 32'(q1_addr.size()), 32'd31);
      for (int k = 0; k < q1_addr.size(); k++) begin
         exp_d = (k + 1 == 12) ? 32'hCAFE_F00D : 32'h1000_0000 + 32'(k + 1);
         chk("t2_addr", {27'd0, q1_addr[k]}, 32'(k + 1));
         chk("t2_data", q1_data[k], exp_d);
      end
      regs1[10] = 32'h1000_000A;
      regs1[12] = 32'h1000_000C;

      // Reset during beat 15.
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      n = 0;
      while (!(valid1 && out_addr1 == 5'd15) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("reach_15", {27'd0, out_addr1}, 32'd15);
      rst1 = 1'b1;
      @(negedge clk);
      rst1 = 1'b0;
      chk("abort_valid", {31'd0, valid1}, 32'd0);
      chk("abort_busy", {31'd0, busy1}, 32'd0);
      dn = 0;
      for (int i = 0; i < 10; i++) begin
         if (done1) dn++;
         @(negedge clk);
      end
      chk("abort_no_done", 32'(dn), 32'd0);
      start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      n = 0;
      while (!valid1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      chk("restart_addr", {27'd0, out_addr1}, 32'd1);
      chk("restart_data", out_data1, 32'h1000_0001);
      n = 0;
      while (!done1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("restart_done", {31'd0, done1}, 32'd1);

      // Random backpressure, register writes and start noise.
      for (int i = 0; i < 1500; i++) begin
         ready1 = ($urandom_range(0, 3) != 0);
         start1 = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 3) == 0) regs1[$urandom_range(1, 31)] = $urandom;
         @(negedge clk);
      end
      ready1 = 1'b1; start1 = 1'b0;
      n = 0;
      while ((busy1 || done1) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("rand_idle", {31'd0, busy1}, 32'd0);

      // Second instance: x0 included, LAST_REG=3.
      start2 = 1'b1;
      @(negedge clk);
      start2 = 1'b0;
      n = 1;
      while (!done2 && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("i2_done_cycle", 32'(n), 32'd9);
      chk("i2_beats", 32'(q2_addr.size()), 32'd4);
      for (int k = 0; k < q2_addr.size(); k++) begin
         exp_d = (k == 0) ? 32'd0 : 32'h1000_0000 + 32'(k);
         chk("i2_addr", {27'd0, q2_addr[k]}, 32'(k));
         chk("i2_data", q2_data[k], exp_d);
         chk("i2_last", {31'd0, q2_last[k]}, (k == 3) ? 32'd1 : 32'd0);
      end
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1);
   end

endmodule
